lcd_byte_sequencer: RTL and testbench
=====================================

# lcd_byte_sequencer

Sequences one 8-bit LCD transfer (command or data) onto the Spartan-3E 4-bit character-LCD bus. Splits the byte into high then low nibble, generates RS setup, a 12-cycle E pulse per nibble and the inter-nibble and post-byte execution waits. Sits between the LCD power-on init / text-writer logic, which hands it bytes over a valid/ready handshake, and the LCD pins. It runs at 50 MHz and is the only driver of the LCD pins once init has finished.

## Interface
Parameters:
- SETUP_CYCLES, 2: cycles RS/data are stable before E rises.
- E_PULSE_CYCLES, 12: E high time per nibble; must be ≥ 12.
- NIBBLE_GAP_CYCLES, 50: E-low gap between high and low nibble (1 µs).
- BYTE_WAIT_CYCLES, 2000: wait after the low nibble for normal commands and data (40 µs).
- CLEAR_WAIT_CYCLES, 82000: wait after the low nibble for Clear Display (0x01) or Return Home (0x02/0x03) when RS=0 (1.64 ms).

Ports:
- Clock  in  1  system clock, 50 MHz.
- Reset  in  1  synchronous, active-high reset.
- iValid  in  1  byte offered.
- oReady  out  1  sequencer idle; a transfer happens on a rising edge where iValid && oReady.
- iByte  in  8  byte to write.
- iRegisterSelect  in  1  0=command, 1=data; latched with iByte.
- oBusy  out  1  high from the accept edge until the post-byte wait expires.
- oLCD_Enabled  out  1  LCD E.
- oLCD_RegisterSelect  out  1  LCD RS.
- oLCD_Data  out  4  LCD DB[7:4].
- oLCD_ReadWrite  out  1  constant 0 (write only).
- oLCD_StrataFlashControl  out  1  constant 1 (StrataFlash disabled).

## Operation
- States: IDLE, HI_SETUP, HI_PULSE, GAP, LO_SETUP, LO_PULSE, WAIT.
- IDLE: oReady=1 (forced 0 while Reset is high). E=0. On accept, latch byte and RS, then go to HI_SETUP.
- HI_SETUP: Data=byte[7:4], RS=latched value, E=0. Lasts SETUP_CYCLES, then HI_PULSE.
- HI_PULSE: same data, E=1. Lasts E_PULSE_CYCLES, then GAP.
- GAP: E=0, data held at byte[7:4]. Lasts NIBBLE_GAP_CYCLES, then LO_SETUP.
- LO_SETUP and LO_PULSE: same as the high-nibble states, using byte[3:0].
- WAIT: E=0, data held. Wait length is CLEAR_WAIT_CYCLES if RS=0 and byte[7:1]==7'b0000000 or byte==8'h02/8'h03, otherwise BYTE_WAIT_CYCLES. Then IDLE.
- One 32-bit counter, cleared on every state change. A state exits when counter == length−1. No overflow is possible for legal parameters.
- iValid while busy is ignored. iByte and iRegisterSelect changes after the accept edge have no effect.
- oBusy = (state != IDLE).
- All LCD outputs are registered; E never glitches.

## Timing
- Reset values: state IDLE, oLCD_Enabled=0, oLCD_Data=0, oLCD_RegisterSelect=0, oBusy=0, oReady=0 while Reset is high and 1 on the first cycle after reset release.
- Accept at edge T0. Then:
  - E rises at T0+SETUP_CYCLES.
  - E falls at T0+SETUP+E_PULSE.
  - Low nibble is driven at T0+SETUP+E_PULSE+GAP.
  - Second E falls at T0+2·SETUP+2·E_PULSE+GAP.
  - oReady returns WAIT cycles later.
- With defaults, accept-to-oReady latency is 2078 cycles for normal bytes and 84078 for clear/home.
- Back-to-back transfers: a new byte can be accepted on the same edge at which oReady is first high. There are no dead cycles.
- Reset mid-transfer: at the next edge, E=0 and all outputs return to reset values. The partial byte is dropped and is not replayed.
- Reset and iValid on the same edge: Reset wins, and no transfer occurs.

## Structure
- Shared include lcd_defines.vh holds:
  - state encodings (`LCD_SEQ_STATE_*`);
  - default timing constants at 50 MHz (15 ms, 4.1 ms, 100 µs, 40 µs, 1.64 ms, 12-cycle E);
  - command opcodes (CLEAR 8'h01, HOME 8'h02).
  
  The power-on init controller uses the same file.
- One natural sub-module: lcd_wait_timer. It is a loadable 32-bit counter with inputs load and length, and output done. It is reused by the init controller.

## Test plan
- After reset, send 0x28 with RS=0. Expect:
  - Data=0x2 with E high for exactly 12 cycles starting at T0+2.
  - 50 cycles of gap, then Data=0x8 with 12 E cycles.
  - oReady high at T0+2078.
- Send 0x41 with RS=1. Expect RS=1 throughout, nibbles 0x4 then 0x1, and the 2000-cycle wait.
- Send 0x01 with RS=0. Expect oReady to stay low until T0+84078. Then send 0x01 with RS=1 (data) and expect the 2078-cycle latency.
- Hold iValid high with a stream 0x30, 0x31, 0x32. Expect:
  - exactly three transfers, each accepted on the first oReady cycle;
  - iByte changes during busy have no effect on oLCD_Data.
- Assert Reset for 1 cycle during HI_PULSE of 0x48. Expect E=0 and Data=0 on the next edge, and oReady=1 after release. A following 0x48 completes normally.
- Hold Reset and iValid high together. Expect no accept and no E pulse, and oReady=0 throughout.

Source files
------------

// File: rtl/lcd_byte_sequencer_pkg.sv
// Shared state encoding, default 50 MHz timing and LCD opcodes used by the
// byte sequencer and the power-on init controller.
package lcd_byte_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HI_SETUP = 3'd1,
        ST_HI_PULSE = 3'd2,
        ST_GAP      = 3'd3,
        ST_LO_SETUP = 3'd4,
        ST_LO_PULSE = 3'd5,
        ST_WAIT     = 3'd6
    } seq_state_t;

    localparam int unsigned DEF_SETUP_CYCLES      = 32'd2;
    localparam int unsigned DEF_E_PULSE_CYCLES    = 32'd12;
    localparam int unsigned DEF_NIBBLE_GAP_CYCLES = 32'd50;
    localparam int unsigned DEF_BYTE_WAIT_CYCLES  = 32'd2000;
    localparam int unsigned DEF_CLEAR_WAIT_CYCLES = 32'd82000;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // Clear Display and Return Home (0x00..0x03 as commands) need the long wait.
    function automatic logic needs_long_wait(input logic rs, input logic [7:0] data);
        return !rs && ((data[7:1] == CMD_CLEAR[7:1]) || (data[7:1] == CMD_HOME[7:1]));
    endfunction

endpackage

// File: rtl/lcd_wait_timer.sv
// Loadable 32-bit cycle counter; done flags the last cycle of a length-cycle interval.
module lcd_wait_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] length,
    output logic        done
);

    logic [31:0] count_r;

    // Count cycles since the last load.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            count_r <= 32'd0;
        end else begin
            count_r <= count_r + 32'd1;
        end
    end

    assign done = (count_r == length - 32'd1);

endmodule

// File: rtl/lcd_byte_sequencer.sv
// Writes one command/data byte to the 4-bit character LCD as two E-strobed
// nibbles, followed by the execution wait the LCD needs for that byte.
module lcd_byte_sequencer
    import lcd_byte_sequencer_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES      = DEF_SETUP_CYCLES,
    parameter int unsigned E_PULSE_CYCLES    = DEF_E_PULSE_CYCLES,
    parameter int unsigned NIBBLE_GAP_CYCLES = DEF_NIBBLE_GAP_CYCLES,
    parameter int unsigned BYTE_WAIT_CYCLES  = DEF_BYTE_WAIT_CYCLES,
    parameter int unsigned CLEAR_WAIT_CYCLES = DEF_CLEAR_WAIT_CYCLES
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iValid,
    output logic       oReady,
    input  logic [7:0] iByte,
    input  logic       iRegisterSelect,
    output logic       oBusy,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic [3:0] oLCD_Data,
    output logic       oLCD_ReadWrite,
    output logic       oLCD_StrataFlashControl
);

    seq_state_t  state_r;
    logic        ready_r;
    logic        e_r;
    logic [3:0]  data_r;
    logic        rs_r;
    logic [3:0]  lo_nibble_r;
    logic        long_wait_r;
    logic [31:0] length_s;
    logic        load_s;
    logic        done_s;

    // Select the duration of the state currently being timed.
    always_comb begin
        length_s = 32'd1;
        case (state_r)
            ST_HI_SETUP, ST_LO_SETUP: length_s = SETUP_CYCLES;
            ST_HI_PULSE, ST_LO_PULSE: length_s = E_PULSE_CYCLES;
            ST_GAP:                   length_s = NIBBLE_GAP_CYCLES;
            ST_WAIT:                  length_s = long_wait_r ? CLEAR_WAIT_CYCLES : BYTE_WAIT_CYCLES;
            default:                  length_s = 32'd1;
        endcase
    end

    // The timer restarts on every state change and is held clear while idle.
    assign load_s = (state_r == ST_IDLE) || done_s;

    lcd_wait_timer u_timer (
        .clk    (Clock),
        .rst    (Reset),
        .load   (load_s),
        .length (length_s),
        .done   (done_s)
    );

    // Sequencer FSM; every LCD pin is driven straight from a register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r     <= ST_IDLE;
            ready_r     <= 1'b1;
            e_r         <= 1'b0;
            data_r      <= 4'h0;
            rs_r        <= 1'b0;
            lo_nibble_r <= 4'h0;
            long_wait_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (iValid) begin
                        state_r     <= ST_HI_SETUP;
                        ready_r     <= 1'b0;
                        data_r      <= iByte[7:4];
                        rs_r        <= iRegisterSelect;
                        lo_nibble_r <= iByte[3:0];
                        long_wait_r <= needs_long_wait(iRegisterSelect, iByte);
                    end
                end
                ST_HI_SETUP: begin
                    if (done_s) begin
                        state_r <= ST_HI_PULSE;
                        e_r     <= 1'b1;
                    end
                end
                ST_HI_PULSE: begin
                    if (done_s) begin
                        state_r <= ST_GAP;
                        e_r     <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (done_s) begin
                        state_r <= ST_LO_SETUP;
                        data_r  <= lo_nibble_r;
                    end
                end
                ST_LO_SETUP: begin
                    if (done_s) begin
                        state_r <= ST_LO_PULSE;
                        e_r     <= 1'b1;
                    end
                end
                ST_LO_PULSE: begin
                    if (done_s) begin
                        state_r <= ST_WAIT;
                        e_r     <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (done_s) begin
                        state_r <= ST_IDLE;
                        ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                    e_r     <= 1'b0;
                end
            endcase
        end
    end

    // ready_r resets to 1 so the sequencer is ready the moment Reset drops.
    assign oReady                  = ready_r & ~Reset;
    assign oBusy                   = ~ready_r;
    assign oLCD_Enabled            = e_r;
    assign oLCD_RegisterSelect     = rs_r;
    assign oLCD_Data               = data_r;
    assign oLCD_ReadWrite          = 1'b0;
    assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_byte_sequencer.sv
// Scoreboard bench: accepted bytes are queued with their expected latency and
// compared against the nibbles, E timing and RS reconstructed from the LCD pins.
`timescale 1ns/1ps
module tb_lcd_byte_sequencer;

    localparam int SETUP      = 2;
    localparam int EPULSE     = 12;
    localparam int GAP        = 50;
    localparam int BWAIT      = 2000;
    localparam int CWAIT      = 8200;  // clear/home wait shortened to keep the run short
    localparam int LO_RISE    = 2 * SETUP + EPULSE + GAP;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       iValid = 1'b0;
    logic [7:0] iByte = 8'h00;
    logic       iRS = 1'b0;
    logic       oReady, oBusy, oLCD_Enabled, oLCD_RegisterSelect, oLCD_ReadWrite, oLCD_StrataFlashControl;
    logic [3:0] oLCD_Data;

    lcd_byte_sequencer #(
        .SETUP_CYCLES      (SETUP),
        .E_PULSE_CYCLES    (EPULSE),
        .NIBBLE_GAP_CYCLES (GAP),
        .BYTE_WAIT_CYCLES  (BWAIT),
        .CLEAR_WAIT_CYCLES (CWAIT)
    ) dut (
        .Clock                   (Clock),
        .Reset                   (Reset),
        .iValid                  (iValid),
        .oReady                  (oReady),
        .iByte                   (iByte),
        .iRegisterSelect         (iRS),
        .oBusy                   (oBusy),
        .oLCD_Enabled            (oLCD_Enabled),
        .oLCD_RegisterSelect     (oLCD_RegisterSelect),
        .oLCD_Data               (oLCD_Data),
        .oLCD_ReadWrite          (oLCD_ReadWrite),
        .oLCD_StrataFlashControl (oLCD_StrataFlashControl)
    );

    always #10 Clock = ~Clock;

    typedef struct packed {
        logic [7:0]  b;
        logic        rs;
        logic [31:0] lat;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    exp_t nxt;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
    endtask

    function automatic int exp_lat(input logic [7:0] b, input logic rs);
        return 2 * SETUP + 2 * EPULSE + GAP + ((!rs && b <= 8'h03) ? CWAIT : BWAIT);
    endfunction

    // Monitor state
    logic       pend = 1'b0;
    logic       in_xfer = 1'b0;
    logic       e_prev = 1'b0;
    logic       rs_bad = 1'b0;
    logic       data_bad = 1'b0;
    logic       stream_mode = 1'b0;
    int         t0 = 0, nib_cnt = 0, e_len = 0, stray_e = 0, accepts = 0, last_ready = 0, stream_acc = 0;
    int         rise[2];
    int         len[2];
    logic [3:0] nib[2];

    always @(negedge Clock) begin
        if (pend) begin
            pend = 1'b0;
            in_xfer = 1'b1;
            t0 = cyc;
            nib_cnt = 0; e_len = 0; e_prev = 1'b0; rs_bad = 1'b0; data_bad = 1'b0;
            rise[0] = -1; rise[1] = -1; len[0] = -1; len[1] = -1;
            accepts++;
            if (stream_mode) begin
                if (stream_acc > 0) check("stream_no_dead_cycle", t0, last_ready + 1);
                stream_acc++;
            end
            check("busy_after_accept", oBusy, 1'b1);
        end
        if (in_xfer) begin
            if (Reset) begin
                in_xfer = 1'b0;
                if (sb.size() > 0) cur = sb.pop_front();
            end else begin
                cur = sb[0];
                if (oLCD_RegisterSelect !== cur.rs) rs_bad = 1'b1;
                if (oLCD_Enabled) begin
                    if (nib_cnt < 2) begin
                        if (!e_prev) begin
                            rise[nib_cnt] = cyc - t0;
                            nib[nib_cnt] = oLCD_Data;
                        end else if (oLCD_Data !== nib[nib_cnt]) begin
                            data_bad = 1'b1;
                        end
                    end
                    e_len++;
                end else if (e_prev) begin
                    if (nib_cnt < 2) len[nib_cnt] = e_len;
                    nib_cnt++;
                    e_len = 0;
                end
                e_prev = oLCD_Enabled;
                if (oReady) begin
                    check("byte_value", {nib[0], nib[1]}, cur.b);
                    check("rs_stable", rs_bad, 1'b0);
                    check("data_stable_in_e", data_bad, 1'b0);
                    check("nibble_count", nib_cnt, 2);
                    check("hi_e_rise", rise[0], SETUP);
                    check("hi_e_len", len[0], EPULSE);
                    check("lo_e_rise", rise[1], LO_RISE);
                    check("lo_e_len", len[1], EPULSE);
                    check("latency", cyc - t0, cur.lat);
                    last_ready = cyc;
                    in_xfer = 1'b0;
                    cur = sb.pop_front();
                end else if (cyc - t0 > CWAIT + 1000) begin
                    check("xfer_timeout", cyc - t0, cur.lat);
                    in_xfer = 1'b0;
                    cur = sb.pop_front();
                end
            end
        end else if (oLCD_Enabled === 1'b1) begin
            stray_e++;
        end
        if (iValid && oReady && !Reset) begin
            pend = 1'b1;
            nxt.b = iByte;
            nxt.rs = iRS;
            nxt.lat = exp_lat(iByte, iRS);
            sb.push_back(nxt);
        end
    end

    task automatic send(input logic [7:0] b, input logic rs);
        int n = 0;
        @(posedge Clock); #1;
        iValid = 1'b1; iByte = b; iRS = rs;
        @(negedge Clock);
        while (!oReady && n < 20000) begin
            @(negedge Clock);
            n++;
        end
        check("ready_for_send", oReady, 1'b1);
        @(posedge Clock); #1;
        iValid = 1'b0; iByte = ~b; iRS = ~rs;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge Clock);
        while ((in_xfer || pend) && n < 20000) begin
            @(negedge Clock);
            n++;
        end
        check("idle_reached", in_xfer, 1'b0);
    endtask

    initial begin
        #(80000 * 20);
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0, a0, bad_ready, base;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("rst_e", oLCD_Enabled, 1'b0);
        check("rst_data", oLCD_Data, 4'h0);
        check("rst_rs", oLCD_RegisterSelect, 1'b0);
        check("rst_ready", oReady, 1'b0);
        check("rst_busy", oBusy, 1'b0);
        check("rw_const", oLCD_ReadWrite, 1'b0);
        check("sf_const", oLCD_StrataFlashControl, 1'b1);
        @(posedge Clock); #1 Reset = 1'b0;
        @(negedge Clock);
        check("ready_after_release", oReady, 1'b1);

        send(8'h28, 1'b0); wait_idle();
        send(8'h41, 1'b1); wait_idle();
        send(8'h01, 1'b0); wait_idle();
        send(8'h01, 1'b1); wait_idle();
        send(8'h02, 1'b0); wait_idle();
        send(8'h04, 1'b0); wait_idle();

        // Stream with iValid held high; iByte moves on while each byte is in flight.
        stream_mode = 1'b1;
        base = accepts;
        @(posedge Clock); #1;
        iValid = 1'b1; iByte = 8'h30; iRS = 1'b0;
        for (int i = 0; i < 3; i++) begin
            int n = 0;
            @(negedge Clock);
            while (!oReady && n < 20000) begin
                @(negedge Clock);
                n++;
            end
            @(posedge Clock); #1;
            if (i < 2) iByte = 8'h31 + 8'(i);
            else iValid = 1'b0;
        end
        wait_idle();
        repeat (20) @(negedge Clock);
        check("stream_count", accepts - base, 3);
        stream_mode = 1'b0;

        // Reset during the high-nibble E pulse of 0x48.
        send(8'h48, 1'b0);
        begin
            int n = 0;
            @(negedge Clock);
            while (!oLCD_Enabled && n < 100) begin
                @(negedge Clock);
                n++;
            end
        end
        check("hi_pulse_seen", oLCD_Enabled, 1'b1);
        @(posedge Clock); #1 Reset = 1'b1;
        @(negedge Clock);
        check("ready_low_in_reset", oReady, 1'b0);
        @(posedge Clock); #1 Reset = 1'b0;
        @(negedge Clock);
        check("mid_rst_e", oLCD_Enabled, 1'b0);
        check("mid_rst_data", oLCD_Data, 4'h0);
        check("mid_rst_busy", oBusy, 1'b0);
        check("mid_rst_ready", oReady, 1'b1);
        s0 = stray_e;
        repeat (100) @(negedge Clock);
        check("no_replay", stray_e - s0, 0);
        send(8'h48, 1'b0); wait_idle();

        // Reset and iValid together.
        s0 = stray_e; a0 = accepts; bad_ready = 0;
        @(posedge Clock); #1;
        Reset = 1'b1; iValid = 1'b1; iByte = 8'h55; iRS = 1'b1;
        repeat (20) begin
            @(negedge Clock);
            if (oReady !== 1'b0) bad_ready++;
        end
        @(posedge Clock); #1;
        Reset = 1'b0; iValid = 1'b0;
        repeat (30) @(negedge Clock);
        check("rst_valid_ready_low", bad_ready, 0);
        check("rst_valid_no_accept", accepts - a0, 0);
        check("rst_valid_no_e", stray_e - s0, 0);
        check("rst_valid_busy", oBusy, 1'b0);
        check("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
